// File: rtl/mini_src_pkg.sv
// Shared Mini-SRC datapath types and constants.
// Used by the HI/LO result-register unit and its watchdog.
package mini_src_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } hilo_state_t;

  localparam logic MF_SEL_LO = 1'b0;
  localparam logic MF_SEL_HI = 1'b1;

  localparam int DEF_TIMEOUT = 40;

endpackage

// File: rtl/hilo_watchdog.sv
// Pending-cycle counter for the HI/LO unit.
// Flags expiry once TIMEOUT cycles have elapsed since the last clear.
module hilo_watchdog
  import mini_src_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wcnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wcnt <= '0;
    end else if (clear) begin
      wcnt <= '0;
    end else if (en && wcnt != LAST) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  assign expired = en & (wcnt == LAST);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO result registers with mul/div result handshake,
// MF/MT interlock and a watchdog on the outstanding operation.
module hilo_unit
  import mini_src_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             op_start,
  input  logic             op_div,
  output logic             op_stall,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_hi,
  input  logic [WIDTH-1:0] res_lo,
  output logic             res_ready,
  input  logic             mt_hi_we,
  input  logic             mt_lo_we,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             mf_req,
  input  logic             mf_sel,
  output logic [WIDTH-1:0] mf_data,
  output logic             mf_valid,
  output logic             stall,
  output logic             busy,
  output logic             last_div,
  output logic             err_timeout,
  output logic             err_spurious
);

  hilo_state_t state, state_nx;

  logic             pending;
  logic             accept;
  logic             issue;
  logic             abort;
  logic             spurious;
  logic             expired;
  logic             mt_ok;
  logic             mf_ok;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  assign pending = (state == WAIT);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    issue    = 1'b0;
    abort    = 1'b0;
    spurious = 1'b0;
    unique case (state)
      IDLE: begin
        spurious = res_valid;
        if (op_start) begin
          issue    = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (res_valid) begin
          accept = 1'b1;
          if (op_start) begin
            issue = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else if (expired) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  assign res_ready = pending;
  assign op_stall  = pending & ~res_valid;
  assign stall     = pending & (mf_req | mt_hi_we | mt_lo_we);
  assign mt_ok     = ~pending;
  assign mf_ok     = mf_req & ~pending;

  hilo_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .clr    (clr),
    .clear  (issue | ~pending),
    .en     (pending),
    .expired(expired)
  );

  // A result and an MT write can never coincide: MT is blocked while pending.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hi <= '0;
      lo <= '0;
    end else if (accept) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (mt_ok) begin
      if (mt_hi_we) hi <= mt_data;
      if (mt_lo_we) lo <= mt_data;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mf_data  <= '0;
      mf_valid <= 1'b0;
    end else begin
      mf_valid <= mf_ok;
      if (mf_ok) begin
        mf_data <= (mf_sel == MF_SEL_HI) ? hi : lo;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      busy         <= 1'b0;
      last_div     <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      busy <= (state_nx == WAIT);
      if (issue)    last_div     <= op_div;
      if (abort)    err_timeout  <= 1'b1;
      if (spurious) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed scenarios plus
// randomized traffic against a timestamp-based reference model.
module tb_hilo_unit;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        clr;
  logic        op_start, op_div, res_valid;
  logic [31:0] res_hi, res_lo, mt_data;
  logic        mt_hi_we, mt_lo_we, mf_req, mf_sel;
  logic        op_stall, res_ready, mf_valid, stall;
  logic        busy, last_div, err_timeout, err_spurious;
  logic [31:0] mf_data;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  bit          m_pend, m_mfv, m_busy, m_last, m_eto, m_esp;
  int          m_issue;
  int          cyc = 0;
  logic [31:0] m_hi, m_lo, m_mfd;

  always #5 clk = ~clk;

  hilo_unit #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .clr         (clr),
    .op_start    (op_start),
    .op_div      (op_div),
    .op_stall    (op_stall),
    .res_valid   (res_valid),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .res_ready   (res_ready),
    .mt_hi_we    (mt_hi_we),
    .mt_lo_we    (mt_lo_we),
    .mt_data     (mt_data),
    .mf_req      (mf_req),
    .mf_sel      (mf_sel),
    .mf_data     (mf_data),
    .mf_valid    (mf_valid),
    .stall       (stall),
    .busy        (busy),
    .last_div    (last_div),
    .err_timeout (err_timeout),
    .err_spurious(err_spurious)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_pend = 0; m_mfv = 0; m_busy = 0; m_last = 0;
    m_eto = 0; m_esp = 0; m_issue = 0;
    m_hi = '0; m_lo = '0; m_mfd = '0;
  endfunction

  task automatic idle();
    op_start = 0; op_div = 0; res_valid = 0;
    res_hi = '0; res_lo = '0;
    mt_hi_we = 0; mt_lo_we = 0; mt_data = '0;
    mf_req = 0; mf_sel = 0;
  endtask

  // let inputs settle, then compare combinational outputs
  task automatic settle();
    #1;
    if (!clr) m_reset();
    chk1("res_ready", res_ready, m_pend);
    chk1("op_stall", op_stall, m_pend && !res_valid);
    chk1("stall", stall, m_pend && (mf_req || mt_hi_we || mt_lo_we));
  endtask

  // advance model and DUT one edge, then compare registered outputs
  task automatic tick();
    bit to;
    if (!clr) begin
      m_reset();
    end else begin
      to = m_pend && !res_valid && (cyc - m_issue == TO);
      if (mf_req && !m_pend) begin
        m_mfd = mf_sel ? m_hi : m_lo;
        m_mfv = 1;
      end else begin
        m_mfv = 0;
      end
      if (m_pend) begin
        if (res_valid) begin
          m_hi = res_hi;
          m_lo = res_lo;
          if (op_start) begin
            m_last  = op_div;
            m_issue = cyc;
          end else begin
            m_pend = 0;
          end
        end else if (to) begin
          m_eto  = 1;
          m_pend = 0;
        end
      end else begin
        if (res_valid) m_esp = 1;
        if (mt_hi_we) m_hi = mt_data;
        if (mt_lo_we) m_lo = mt_data;
        if (op_start) begin
          m_pend  = 1;
          m_issue = cyc;
          m_last  = op_div;
        end
      end
      m_busy = m_pend;
    end
    @(posedge clk);
    #1;
    cyc++;
    chkw("mf_data", mf_data, m_mfd);
    chk1("mf_valid", mf_valid, m_mfv);
    chk1("busy", busy, m_busy);
    chk1("last_div", last_div, m_last);
    chk1("err_timeout", err_timeout, m_eto);
    chk1("err_spurious", err_spurious, m_esp);
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic mf(input logic sel);
    idle();
    mf_req = 1;
    mf_sel = sel;
    cycle();
  endtask

  initial begin
    bit quiet;
    clr = 0;
    idle();
    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      op_start = 1'($urandom); op_div = 1'($urandom);
      res_valid = 1'($urandom); res_hi = $urandom; res_lo = $urandom;
      mt_hi_we = 1'($urandom); mt_lo_we = 1'($urandom);
      mt_data = $urandom; mf_req = 1'($urandom); mf_sel = 1'($urandom);
      cycle();
    end
    chk1("rst_busy_lit", busy, 1'b0);
    chk1("rst_mfv_lit", mf_valid, 1'b0);
    chk1("rst_spur_lit", err_spurious, 1'b0);
    chkw("rst_mfd_lit", mf_data, 32'h0);
    clr = 1;
    idle();
    cycle();
    mf(1'b1);
    chkw("rst_mfhi_lit", mf_data, 32'h0);
    chk1("rst_mfv1_lit", mf_valid, 1'b1);

    // MUL round trip
    idle(); op_start = 1; op_div = 0;
    cycle();
    chk1("mul_busy_lit", busy, 1'b1);
    idle(); mf_req = 1; mf_sel = 0;
    settle();
    chk1("mul_stall_lit", stall, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) cycle();
    res_valid = 1; res_hi = 32'hFFFFFFFF; res_lo = 32'hFFFFFFFA;
    cycle();
    idle(); mf_req = 1; mf_sel = 0;
    settle();
    chk1("mul_unstall_lit", stall, 1'b0);
    tick();
    chkw("mul_mflo_lit", mf_data, 32'hFFFFFFFA);
    chk1("mul_lastdiv_lit", last_div, 1'b0);

    // back-to-back issue
    idle(); op_start = 1; op_div = 0;
    cycle();
    idle(); cycle();
    res_valid = 1; res_hi = 32'h11; res_lo = 32'h22;
    op_start = 1; op_div = 1;
    settle();
    chk1("b2b_opstall_lit", op_stall, 1'b0);
    tick();
    chk1("b2b_busy_lit", busy, 1'b1);
    chk1("b2b_lastdiv_lit", last_div, 1'b1);
    idle(); op_start = 1; op_div = 0;
    settle();
    chk1("b2b_opstall2_lit", op_stall, 1'b1);
    tick();

    // MT interlock
    idle(); mt_hi_we = 1; mt_data = 32'h12345678;
    settle();
    chk1("mt_stall_lit", stall, 1'b1);
    tick();
    idle(); res_valid = 1; res_hi = 32'd7; res_lo = 32'd3;
    cycle();
    chk1("mt_lastdiv_lit", last_div, 1'b1);
    mf(1'b1);
    chkw("mt_hi7_lit", mf_data, 32'd7);
    idle(); mt_hi_we = 1; mt_data = 32'h12345678;
    cycle();
    mf(1'b1);
    chkw("mt_hi_lit", mf_data, 32'h12345678);

    // watchdog timeout
    idle(); op_start = 1;
    cycle();
    idle();
    for (int i = 1; i <= TO; i++) begin
      cycle();
      if (i == TO - 1) begin
        chk1("to_busy39_lit", busy, 1'b1);
        chk1("to_err39_lit", err_timeout, 1'b0);
      end
    end
    chk1("to_err_lit", err_timeout, 1'b1);
    chk1("to_busy_lit", busy, 1'b0);
    idle(); res_valid = 1; res_hi = 32'hDEAD; res_lo = 32'hBEEF;
    cycle();
    chk1("to_spur_lit", err_spurious, 1'b1);
    mf(1'b1);
    chkw("to_hi_lit", mf_data, 32'h12345678);
    mf(1'b0);
    chkw("to_lo_lit", mf_data, 32'd3);

    // reset mid-operation
    idle(); op_start = 1;
    cycle();
    idle(); cycle(); cycle();
    clr = 0;
    cycle();
    clr = 1;
    res_valid = 1; res_hi = 32'hAAAA5555; res_lo = 32'h5555AAAA;
    cycle();
    chk1("rmid_spur_lit", err_spurious, 1'b1);
    chk1("rmid_to_lit", err_timeout, 1'b0);
    mf(1'b1);
    chkw("rmid_hi_lit", mf_data, 32'h0);
    mf(1'b0);
    chkw("rmid_lo_lit", mf_data, 32'h0);

    // randomized traffic with quiet windows for timeouts
    for (int i = 0; i < 3000; i++) begin
      quiet = (i % 400) >= 340;
      idle();
      clr       = ($urandom % 600) != 0;
      op_start  = quiet ? (i % 400 == 340) : (($urandom % 3) == 0);
      op_div    = 1'($urandom);
      res_valid = quiet ? 1'b0 : (($urandom % 6) == 0);
      res_hi    = $urandom;
      res_lo    = $urandom;
      mt_hi_we  = ($urandom % 6) == 0;
      mt_lo_we  = ($urandom % 6) == 0;
      mt_data   = $urandom;
      mf_req    = 1'($urandom);
      mf_sel    = 1'($urandom);
      cycle();
    end
    clr = 1;
    idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

HI/LO result-register unit of the Mini-SRC datapath, directly downstream of the 32-bit multiplier and divider. Tracks one outstanding mul/div operation and accepts its 64-bit result through a valid/ready handshake into the architectural HI and LO registers. Serves MFHI/MFLO reads and MTHI/MTLO writes, and interlocks both against the outstanding operation. A watchdog aborts any operation whose result never arrives.

## Interface
- `WIDTH`, 32: data width of HI, LO and the bus.
- `TIMEOUT`, 40: maximum cycles pending before abort; must be ≥ 34.
- `clk` in 1: single clock; all state updates on the rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `op_start` in 1: issue pulse for a mul/div operation.
- `op_div` in 1: operation kind sampled with `op_start`; 0 = MUL, 1 = DIV.
- `op_stall` out 1: combinational; `op_start` cannot be accepted this cycle.
- `res_valid` in 1: result offered by the multiplier or divider.
- `res_hi`, `res_lo` in WIDTH: result halves; for DIV, HI = remainder and LO = quotient.
- `res_ready` out 1: combinational; equals `pending`.
- `mt_hi_we`, `mt_lo_we` in 1: MTHI and MTLO write requests.
- `mt_data` in WIDTH: write data.
- `mf_req` in 1: read request.
- `mf_sel` in 1: read select; 0 = LO, 1 = HI.
- `mf_data` out WIDTH: registered read data.
- `mf_valid` out 1: registered; `mf_data` is valid.
- `stall` out 1: combinational; an MF or MT request is blocked this cycle.
- `busy` out 1: registered `pending`.
- `last_div` out 1: kind of the last accepted operation.
- `err_timeout` out 1: sticky; set on watchdog abort.
- `err_spurious` out 1: sticky; set on a result received while idle.

## Operation
- Two states, IDLE and WAIT. `pending` is 1 in WAIT and 0 in IDLE. Counter `wcnt` is `$clog2(TIMEOUT+1)` bits.
- **IDLE + `op_start`:** go to WAIT, clear `wcnt`, latch `op_div` into `last_div`. `op_stall` is 0.
- **WAIT + `res_valid`:** handshake completes (`res_ready` = 1). Write HI ← `res_hi` and LO ← `res_lo`, then go to IDLE.
- **WAIT + `res_valid` + `op_start` in the same cycle:** accept the result and the new issue together. Stay in WAIT, clear `wcnt`, `op_stall` = 0.
- **WAIT + `op_start` without `res_valid`:** `op_stall` = 1 and the issue is ignored.
- **WAIT, no result:** `wcnt` increments each cycle. When `wcnt` reaches `TIMEOUT`−1 and `res_valid` is 0, set `err_timeout`, go to IDLE, and leave HI/LO unchanged.
- **IDLE + `res_valid`:** set `err_spurious` and drop the result; HI/LO unchanged.
- **MT writes:** blocked when `pending` (`stall` = 1, no write). Otherwise the selected register ← `mt_data`. Both write enables may be set together and both registers are written.
- **MT write + `op_start` in the same IDLE cycle:** the write happens first, then WAIT is entered.
- **MF read:** blocked when `pending` (`stall` = 1, `mf_valid` = 0). Otherwise `mf_data` ← the selected register and `mf_valid` = 1 on the next cycle.
- **MF read + MT write to the same register in one cycle:** the read returns the old value; there is no bypass.
- **Sticky errors:** cleared only by `clr`.

## Timing
- **Reset values:** HI, LO, `mf_data` = 0; `mf_valid`, `busy`, `last_div`, `err_timeout`, `err_spurious` = 0; state IDLE, `wcnt` = 0.
- **Reset mid-operation:** the pending operation is discarded and a later `res_valid` raises `err_spurious`.
- **Issue → busy:** `busy` is 1 on the cycle after `op_start`.
- **Result → readable:** result accepted at edge N. An MF request in cycle N+1 is unstalled, with `mf_data`/`mf_valid` at edge N+2.
- **Combinational outputs:** `res_ready`, `op_stall` and `stall` depend only on state and current inputs, with no combinational path to `mf_data`.
- **Watchdog:** abort occurs exactly `TIMEOUT` cycles after the issue edge.

## Structure
- A shared package `mini_src_pkg` holds:
  - the `hilo_state_t` enum (IDLE, WAIT);
  - `MF_SEL_LO` / `MF_SEL_HI` constants;
  - `DEF_TIMEOUT` = 40.
- Sub-module `hilo_watchdog`: holds the `wcnt` counter with clear/enable inputs and a `expired` output, parameterised by `TIMEOUT`.
- HI/LO storage and the FSM stay in the top level.

## Test plan
- **Reset:** assert `clr` = 0 with random inputs → all outputs 0. Release, then MFHI → `mf_data` = 0, `mf_valid` = 1.
- **MUL round trip:** `op_start`, `op_div` = 0. Five cycles later `res_valid` with HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MFLO during the wait → `stall` = 1. MFLO after acceptance → 0xFFFFFFFA, and `last_div` = 0.
- **Back-to-back:** `res_valid` and `op_start` (`op_div` = 1) in the same cycle → result written, `busy` stays 1, `op_stall` = 0, `last_div` = 1. A second `op_start` while waiting → `op_stall` = 1.
- **MT interlock:** MTHI 0x12345678 while pending → `stall` = 1 and HI unchanged. After the result lands (HI = 7), MTHI 0x12345678 then MFHI → 0x12345678.
- **Timeout:** `op_start` with no result for 40 cycles → `err_timeout` = 1 at the 40th edge, `busy` = 0, HI/LO unchanged. A late `res_valid` → `err_spurious` = 1.
- **Reset mid-operation:** `op_start`, pulse `clr` low at cycle 3, then `res_valid` → result dropped, HI/LO = 0, `err_spurious` = 1.
